// File: rtl/sqrt_sig_iter_pkg.sv
// rtl/sqrt_sig_iter_pkg.sv - shared types, widths and helpers for the iterative significand sqrt
package sqrt_sig_iter_pkg;

  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_SQRT_SIG_W = 1 + LAMP_FLOAT_F_DW;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SQRT     = 2'b01,
    OUTSTATE = 2'b10
  } sqrt_state_t;

  function automatic int sqrtIterCnt(input int sig_w, input int dpc);
    return (2 * sig_w) / dpc;
  endfunction

endpackage

// File: rtl/sqrt_sig_iter_step.sv
// rtl/sqrt_sig_iter_step.sv - one combinational restoring square-root step (one root bit)
module sqrt_sig_step #(
  parameter int SIG_W = 8
) (
  input  logic [2*SIG_W+1:0] rem,
  input  logic [2*SIG_W-1:0] q,
  input  logic [1:0]         rad_bits,
  output logic [2*SIG_W+1:0] rem_next,
  output logic               q_bit
);

  localparam int REM_W = 2 * SIG_W + 2;
  localparam int TMP_W = REM_W + 2;

  logic [TMP_W-1:0] cur;
  logic [TMP_W-1:0] sub;
  logic [TMP_W-1:0] trial;

  // Two extra headroom bits keep the brought-down remainder exact before the compare.
  always_comb begin
    cur      = {rem, rad_bits};
    sub      = {2'b00, q, 2'b01};
    trial    = cur - sub;
    q_bit    = (cur >= sub);
    rem_next = q_bit ? trial[REM_W-1:0] : cur[REM_W-1:0];
  end

endmodule

// File: rtl/sqrt_sig_iter.sv
// rtl/sqrt_sig_iter.sv - iterative restoring significand square root, DPC root bits per cycle
module sqrt_sig_iter
  import sqrt_sig_iter_pkg::*;
#(
  parameter int SIG_W = LAMP_SQRT_SIG_W,
  parameter int DPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 doSqrt_i,
  input  logic [SIG_W-1:0]     s_i,
  input  logic                 odd_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [2*SIG_W-1:0]   res_o,
  output logic                 sticky_o
);

  localparam int RES_W = 2 * SIG_W;
  localparam int RAD_W = 4 * SIG_W;
  localparam int REM_W = RES_W + 2;
  localparam int ITER  = sqrtIterCnt(SIG_W, DPC);
  localparam int CNT_W = $clog2(ITER + 1);

  if (!(DPC == 1 || DPC == 2 || DPC == 4) || ((2 * SIG_W) % DPC) != 0) begin : g_bad_dpc
    $error("sqrt_sig_iter: DPC must be 1, 2 or 4 and divide 2*SIG_W");
  end

  sqrt_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [RES_W-1:0] root_q, root_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             sticky_q, sticky_d;

  logic             start;
  logic             last_iter;
  logic [RAD_W-1:0] rad_init;

  logic [REM_W-1:0] rem_c [DPC+1];
  logic [RES_W-1:0] q_c   [DPC+1];
  logic [DPC-1:0]   q_bit;

  assign rem_c[0] = rem_q;
  assign q_c[0]   = root_q;

  for (genvar g = 0; g < DPC; g++) begin : g_step
    sqrt_sig_step #(.SIG_W(SIG_W)) u_step (
      .rem      (rem_c[g]),
      .q        (q_c[g]),
      .rad_bits (rad_q[RAD_W-1-2*g -: 2]),
      .rem_next (rem_c[g+1]),
      .q_bit    (q_bit[g])
    );
    assign q_c[g+1] = {q_c[g][RES_W-2:0], q_bit[g]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rad_q    <= rad_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
    end
  end

  assign last_iter = (state_q == SQRT) && (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (doSqrt_i) state_d = SQRT;
      SQRT:     if (last_iter) state_d = OUTSTATE;
      OUTSTATE: state_d = doSqrt_i ? SQRT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q != SQRT);
    valid_o = (state_q == OUTSTATE);
  end

  assign res_o    = res_q;
  assign sticky_o = sticky_q;
  assign start    = ready_o && doSqrt_i;
  // Radicand is s_i << (3*SIG_W-1+odd_i); an even exponent drops one position.
  assign rad_init = {s_i, {(3*SIG_W){1'b0}}};

  always_comb begin
    cnt_d    = cnt_q;
    rad_d    = rad_q;
    root_d   = root_q;
    rem_d    = rem_q;
    res_d    = res_q;
    sticky_d = sticky_q;
    if (start) begin
      cnt_d  = '0;
      rad_d  = odd_i ? rad_init : (rad_init >> 1);
      root_d = '0;
      rem_d  = '0;
    end else if (state_q == SQRT) begin
      cnt_d  = cnt_q + CNT_W'(1);
      rad_d  = rad_q << (2 * DPC);
      root_d = q_c[DPC];
      rem_d  = rem_c[DPC];
      if (last_iter) begin
        res_d    = q_c[DPC];
        sticky_d = |rem_c[DPC];
      end
    end
  end

endmodule
